// File: rtl/npc_sequencer_pkg.sv
// npc_sequencer_pkg: shared definitions for the next-PC sequencer.
//   - pc_inc encodings (sequential, branch-relative, absolute, stop)
//   - npc_state_e sequencer FSM states
//   - redirect_t pending-redirect record (target + pc_inc code)
package npc_sequencer_pkg;

  localparam logic [1:0] PcIncSeq  = 2'b00;
  localparam logic [1:0] PcIncBr   = 2'b01;
  localparam logic [1:0] PcIncAbs  = 2'b10;
  localparam logic [1:0] PcIncStop = 2'b11;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StHold   = 2'b01,
    StDrain  = 2'b10,
    StHalted = 2'b11
  } npc_state_e;

  typedef struct packed {
    logic [31:0] target;
    logic [1:0]  code;
  } redirect_t;

endpackage

// File: rtl/npc_ras.sv
// npc_ras: circular return-address stack, only instantiated when NPC_RAS_EN is defined.
//   clk_i, clr_ni     clock, async active-low reset (stack empty)
//   push_i / pop_i    push push_data_i / pop the top entry
//   push_data_i       return address to push
//   top_o             current top entry (0 when empty)
//   empty_o, full_o   occupancy flags
// A push when full overwrites the oldest entry. Push+pop together replaces the top in place.
module npc_ras #(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] ptr_q;  // next slot to write
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] top_idx, ptr_nxt;

  assign top_idx = (ptr_q == '0) ? PtrW'(Depth - 1) : ptr_q - 1'b1;
  assign ptr_nxt = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign top_o   = empty_o ? 32'd0 : mem_q[top_idx];

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push_i && pop_i && !empty_o) begin
      mem_q[top_idx] <= push_data_i;
    end else if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
      ptr_q        <= ptr_nxt;
      if (!full_o) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/npc_sequencer.sv
// npc_sequencer: producer side of the PC-register interface.
//   clk_i, clr_ni               clock, async active-low reset
//   current_pc_i                PC register value (word address)
//   stall_i                     hold PC this cycle
//   br_valid_i/br_taken_i/br_imm_i  conditional branch (target = pc + 1 + imm)
//   jmp_valid_i/jmp_target_i    absolute jump
//   ras_push_i/ras_pop_i        call/return (used only with NPC_RAS_EN)
//   halt_req_i                  halt decoded; drains outstanding memory ops first
//   mem_req_i/mem_ack_i         memory op issue/complete
//   next_pc_o, pc_inc_o         combinational next PC and its code
//   halted_o, stall_cycles_o, outst_err_o  registered status
// Build option: define NPC_RAS_EN to add the return-address stack.
module npc_sequencer
  import npc_sequencer_pkg::*;
#(
  parameter int unsigned OutstW   = 4,
  parameter int unsigned RasDepth = 4
) (
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic [31:0] current_pc_i,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_imm_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_target_i,
  input  logic        ras_push_i,
  input  logic        ras_pop_i,
  input  logic        halt_req_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [31:0] next_pc_o,
  output logic [1:0]  pc_inc_o,
  output logic        halted_o,
  output logic [31:0] stall_cycles_o,
  output logic        outst_err_o
);

  npc_state_e        state_q, state_d;
  redirect_t         pend_q, pend_d;
  logic [OutstW-1:0] count_q, count_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic              err_q, err_d;

  logic [31:0] pc_plus1, br_target;
  logic        redir_vld;
  redirect_t   redir;
  logic        ras_pop_act, ras_err;
  logic [31:0] ras_top;

  assign pc_plus1  = current_pc_i + 32'd1;
  assign br_target = current_pc_i + 32'd1 + br_imm_i;

  // Stack only moves on cycles where the sequencer is actually accepting redirects.
  logic ras_op_en;
  assign ras_op_en = (state_q == StRun) && !halt_req_i;

`ifdef NPC_RAS_EN
  logic ras_empty, ras_full;

  npc_ras #(
    .Depth(RasDepth)
  ) u_ras (
    .clk_i      (clk_i),
    .clr_ni     (clr_ni),
    .push_i     (ras_push_i && ras_op_en),
    .pop_i      (ras_pop_i && ras_op_en),
    .push_data_i(pc_plus1),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full)
  );

  logic unused_ras_full;
  assign unused_ras_full = ras_full;
  assign ras_pop_act     = ras_pop_i && ras_op_en;
  assign ras_err         = ras_pop_act && ras_empty;
`else
  localparam int unsigned UnusedRasDepth = RasDepth;
  logic unused_ras;
  assign unused_ras  = ras_push_i ^ ras_pop_i ^ ras_op_en;
  assign ras_pop_act = 1'b0;
  assign ras_err     = 1'b0;
  assign ras_top     = 32'd0;
`endif

  // Redirect mux below halt: ras_pop > jmp > taken branch.
  always_comb begin
    redir_vld = 1'b1;
    redir     = '{target: ras_top, code: PcIncAbs};
    if (ras_pop_act) begin
      redir = '{target: ras_top, code: PcIncAbs};
    end else if (jmp_valid_i) begin
      redir = '{target: jmp_target_i, code: PcIncAbs};
    end else if (br_valid_i && br_taken_i) begin
      redir = '{target: br_target, code: PcIncBr};
    end else begin
      redir_vld = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    next_pc_o = pc_plus1;
    pc_inc_o  = PcIncSeq;
    unique case (state_q)
      StRun, StHold: begin
        if (halt_req_i) begin
          // Pending redirect dropped; halt in the entry cycle when nothing is in flight.
          next_pc_o = current_pc_i;
          pend_d    = '0;
          if (count_q == '0) begin
            pc_inc_o = PcIncStop;
            state_d  = StHalted;
          end else begin
            state_d = StDrain;
          end
        end else if (stall_i) begin
          next_pc_o = current_pc_i;
          // Only the first redirect seen during a stall is kept.
          if (state_q == StRun && redir_vld) begin
            pend_d  = redir;
            state_d = StHold;
          end
        end else if (state_q == StHold) begin
          next_pc_o = pend_q.target;
          pc_inc_o  = pend_q.code;
          pend_d    = '0;
          state_d   = StRun;
        end else if (redir_vld) begin
          next_pc_o = redir.target;
          pc_inc_o  = redir.code;
        end
      end
      StDrain: begin
        next_pc_o = current_pc_i;
        if (count_q == '0) begin
          pc_inc_o = PcIncStop;
          state_d  = StHalted;
        end
      end
      StHalted: begin
        next_pc_o = current_pc_i;
        pc_inc_o  = PcIncStop;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q | ras_err;
    if (mem_req_i && !mem_ack_i) begin
      if (count_q == '1) err_d = 1'b1;
      else count_d = count_q + 1'b1;
    end else if (mem_ack_i && !mem_req_i) begin
      if (count_q == '0) err_d = 1'b1;
      else count_d = count_q - 1'b1;
    end
    stall_cycles_d = stall_cycles_q;
    if (stall_i && (state_q == StRun || state_q == StHold)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q        <= StRun;
      pend_q         <= '0;
      count_q        <= '0;
      stall_cycles_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
      err_q          <= err_d;
    end
  end

  assign halted_o       = (state_q == StHalted);
  assign stall_cycles_o = stall_cycles_q;
  assign outst_err_o    = err_q;

endmodule
